// File: rtl/cordic_rot_iter.sv
// Iterative rotation-mode CORDIC, one micro-rotation per clock, built on a 16-bit two-level CLA.
// Optional gain compensation stage enabled with `define CORDIC_GAIN_COMP_EN.

module cordic_cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum
);
    logic [15:0] g, p, c;
    logic [3:0]  gg, gp, gc;

    always_comb begin
        logic cc;
        g = a & b;
        p = a ^ b;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        // Second level: group carries straight from group generate/propagate
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
        c = '0;
        for (int k = 0; k < 4; k++) begin
            cc = gc[k];
            for (int j = 0; j < 4; j++) begin
                c[4*k+j] = cc;
                cc = g[4*k+j] | (p[4*k+j] & cc);
            end
        end
        sum = p ^ c;
    end
endmodule

`ifdef CORDIC_GAIN_COMP_EN
module cordic_gain_comp (
    input  logic [15:0] v,
    output logic [15:0] r
);
    // r ~= v/K = v/2 + v/8 - v/64 - v/512 - v/8192, every term truncated, sums wrap
    logic signed [15:0] vs;
    logic [15:0] t1, t3, t6, t9, t13, s0, s1, s2;

    assign vs  = $signed(v);
    assign t1  = vs >>> 1;
    assign t3  = vs >>> 3;
    assign t6  = vs >>> 6;
    assign t9  = vs >>> 9;
    assign t13 = vs >>> 13;

    cordic_cla16 u_add0 (.a(t1), .b(t3),   .cin(1'b0), .sum(s0));
    cordic_cla16 u_sub1 (.a(s0), .b(~t6),  .cin(1'b1), .sum(s1));
    cordic_cla16 u_sub2 (.a(s1), .b(~t9),  .cin(1'b1), .sum(s2));
    cordic_cla16 u_sub3 (.a(s2), .b(~t13), .cin(1'b1), .sum(r));
endmodule
`endif

module cordic_rot_iter #(
    parameter int WIDTH = 16,
    parameter int ITER  = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out
);
    localparam logic [3:0] LAST = 4'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
`ifdef CORDIC_GAIN_COMP_EN
        , S_COMP = 2'd3
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       i_q, i_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [WIDTH-1:0] x_out_q, x_out_d, y_out_q, y_out_d, z_out_q, z_out_d;

    logic [2:0][WIDTH-1:0] cla_a, cla_b, cla_s;
    logic [2:0]            cla_ci;
    logic [WIDTH-1:0]      x_sh, y_sh, atan_i;
    logic signed [WIDTH-1:0] z_in_s;
    logic                  z_neg, pre_rot;

    function automatic logic [15:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:  atan_lut = 16'h2000;
            4'd1:  atan_lut = 16'h12E4;
            4'd2:  atan_lut = 16'h09FB;
            4'd3:  atan_lut = 16'h0511;
            4'd4:  atan_lut = 16'h028B;
            4'd5:  atan_lut = 16'h0146;
            4'd6:  atan_lut = 16'h00A3;
            4'd7:  atan_lut = 16'h0051;
            4'd8:  atan_lut = 16'h0029;
            4'd9:  atan_lut = 16'h0014;
            4'd10: atan_lut = 16'h000A;
            4'd11: atan_lut = 16'h0005;
            4'd12: atan_lut = 16'h0003;
            4'd13: atan_lut = 16'h0001;
            default: atan_lut = 16'h0000;
        endcase
    endfunction

    assign x_sh    = $signed(x_q) >>> i_q;
    assign y_sh    = $signed(y_q) >>> i_q;
    assign atan_i  = atan_lut(i_q);
    assign z_neg   = z_q[WIDTH-1];
    assign z_in_s  = $signed(z_in);
    // Angles beyond +/-pi/2 get a half-turn first; exactly +/-pi/2 stays put
    assign pre_rot = (z_in_s > 16'sh4000) || (z_in_s < 16'shC000);

    // Same three adders serve the accept-edge pre-rotation and every micro-rotation
    always_comb begin
        cla_a[0] = x_q;  cla_b[0] = z_neg ? y_sh : ~y_sh;     cla_ci[0] = ~z_neg;
        cla_a[1] = y_q;  cla_b[1] = z_neg ? ~x_sh : x_sh;     cla_ci[1] = z_neg;
        cla_a[2] = z_q;  cla_b[2] = z_neg ? atan_i : ~atan_i; cla_ci[2] = ~z_neg;
        if (state_q == S_IDLE) begin
            if (pre_rot) begin
                cla_a[0] = '0;   cla_b[0] = ~x_in;    cla_ci[0] = 1'b1;
                cla_a[1] = '0;   cla_b[1] = ~y_in;    cla_ci[1] = 1'b1;
                cla_a[2] = z_in; cla_b[2] = 16'h8000; cla_ci[2] = 1'b0;
            end else begin
                cla_a[0] = x_in; cla_b[0] = '0; cla_ci[0] = 1'b0;
                cla_a[1] = y_in; cla_b[1] = '0; cla_ci[1] = 1'b0;
                cla_a[2] = z_in; cla_b[2] = '0; cla_ci[2] = 1'b0;
            end
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_cla
        cordic_cla16 u_cla (.a(cla_a[k]), .b(cla_b[k]), .cin(cla_ci[k]), .sum(cla_s[k]));
    end

`ifdef CORDIC_GAIN_COMP_EN
    logic [WIDTH-1:0] comp_x, comp_y;
    cordic_gain_comp u_comp_x (.v(x_q), .r(comp_x));
    cordic_gain_comp u_comp_y (.v(y_q), .r(comp_y));
`endif

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        z_out_d = z_out_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_ITER;
                    i_d     = 4'd0;
                    x_d     = cla_s[0];
                    y_d     = cla_s[1];
                    z_d     = cla_s[2];
                end
            end
            S_ITER: begin
                x_d = cla_s[0];
                y_d = cla_s[1];
                z_d = cla_s[2];
                i_d = i_q + 4'd1;
                if (i_q == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_d = S_COMP;
`else
                    state_d = S_DONE;
                    x_out_d = cla_s[0];
                    y_out_d = cla_s[1];
                    z_out_d = cla_s[2];
`endif
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            S_COMP: begin
                state_d = S_DONE;
                x_out_d = comp_x;
                y_out_d = comp_y;
                z_out_d = z_q;
            end
`endif
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            x_out_q <= '0;
            y_out_q <= '0;
            z_out_q <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
            z_out_q <= z_out_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign z_out     = z_out_q;
endmodule

// File: tb/tb_cordic_rot_iter.sv
// Bench for cordic_rot_iter: known-angle table, backpressure/reset sequences, randomized scoreboard.
module tb_cordic_rot_iter;
    localparam int ITER = 14;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = ITER + 1;
`else
    localparam int LAT = ITER;
`endif
    localparam int NOPS = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] x_in, y_in, z_in, x_out, y_out, z_out;

    int total = 0;
    int bad   = 0;

    cordic_rot_iter #(.WIDTH(16), .ITER(ITER)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .z_out(z_out)
    );

    always #5 clk = ~clk;

    logic [15:0] atan_tab [14] = '{16'h2000, 16'h12E4, 16'h09FB, 16'h0511, 16'h028B, 16'h0146,
                                   16'h00A3, 16'h0051, 16'h0029, 16'h0014, 16'h000A, 16'h0005,
                                   16'h0003, 16'h0001};

    // Reference: spec algorithm on plain signed 16-bit arithmetic (wraps naturally)
    function automatic void model(input logic [15:0] xi, input logic [15:0] yi, input logic [15:0] zi,
                                  output logic [15:0] xo, output logic [15:0] yo, output logic [15:0] zo);
        logic signed [15:0] x, y, z, t;
        int zs;
        x = xi; y = yi; z = zi;
        zs = $signed(zi);
        if (zs > 16384) begin
            x = -x; y = -y; z = z - 16'sh8000;
        end else if (zs < -16384) begin
            x = -x; y = -y; z = z + 16'sh8000;
        end
        for (int i = 0; i < ITER; i++) begin
            if (z >= 0) begin
                t = x - (y >>> i); y = y + (x >>> i); x = t; z = z - $signed(atan_tab[i]);
            end else begin
                t = x + (y >>> i); y = y - (x >>> i); x = t; z = z + $signed(atan_tab[i]);
            end
        end
`ifdef CORDIC_GAIN_COMP_EN
        x = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9) - (x >>> 13);
        y = (y >>> 1) + (y >>> 3) - (y >>> 6) - (y >>> 9) - (y >>> 13);
`endif
        xo = x; yo = y; zo = z;
    endfunction

    task automatic chk(input string nm, input int act, input int expv, input int tol);
        total++;
        if (act > expv + tol || act < expv - tol) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (+/-%0d)", nm, act, expv, tol);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [15:0] xi, input logic [15:0] yi, input logic [15:0] zi,
                          output int lat, output logic [15:0] xo, output logic [15:0] yo, output logic [15:0] zo);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        in_valid = 1'b1; x_in = xi; y_in = yi; z_in = zi; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin step(); n++; end
        lat = n;
        xo = x_out; yo = y_out; zo = z_out;
        step();
    endtask

    typedef struct {
        logic [15:0] x, y, z;
        int          ex, ey, tol;
    } vec_t;

    vec_t tbl [4];
    logic [15:0] q_x[$], q_y[$], q_z[$];
    logic [15:0] bnd_z [5] = '{16'h4000, 16'hC000, 16'h8000, 16'h4001, 16'hBFFF};

    initial begin
        int lat, n, r;
        logic [15:0] ax, ay, az, mx, my, mz;

`ifdef CORDIC_GAIN_COMP_EN
        tbl[0] = '{16'd16384, 16'd0, 16'h0000, 16384,     0, 8};
        tbl[1] = '{16'd10000, 16'd0, 16'h2000,  7071,  7071, 8};
        tbl[2] = '{16'd10000, 16'd0, 16'h6000, -7071,  7071, 8};
        tbl[3] = '{16'd10000, 16'd0, 16'h8000, -10000,    0, 8};
`else
        tbl[0] = '{16'd16384, 16'd0, 16'h0000, 26981,     0, 4};
        tbl[1] = '{16'd10000, 16'd0, 16'h2000, 11645, 11645, 4};
        tbl[2] = '{16'd10000, 16'd0, 16'h6000, -11645, 11645, 4};
        tbl[3] = '{16'd10000, 16'd0, 16'h8000, -16468,    0, 4};
`endif

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x_in = '0; y_in = '0; z_in = '0;
        step(); step();
        chk("rst_in_ready", int'(in_ready), 1, 0);
        chk("rst_out_valid", int'(out_valid), 0, 0);
        chk("rst_x_out", int'(x_out), 0, 0);
        chk("rst_y_out", int'(y_out), 0, 0);
        chk("rst_z_out", int'(z_out), 0, 0);
        rst = 1'b0;
        step();

        for (int v = 0; v < 4; v++) begin
            run_op(tbl[v].x, tbl[v].y, tbl[v].z, lat, ax, ay, az);
            model(tbl[v].x, tbl[v].y, tbl[v].z, mx, my, mz);
            chk($sformatf("tbl%0d_lat", v), lat, LAT, 0);
            chk($sformatf("tbl%0d_x", v), int'($signed(ax)), tbl[v].ex, tbl[v].tol);
            chk($sformatf("tbl%0d_y", v), int'($signed(ay)), tbl[v].ey, tbl[v].tol);
            chk($sformatf("tbl%0d_zres", v), int'($signed(az)), 0, 2);
            chk($sformatf("tbl%0d_x_model", v), int'($signed(ax)), int'($signed(mx)), 0);
            chk($sformatf("tbl%0d_y_model", v), int'($signed(ay)), int'($signed(my)), 0);
            chk($sformatf("tbl%0d_z_model", v), int'($signed(az)), int'($signed(mz)), 0);
        end

        // Backpressure in DONE with in_valid pulses that must be ignored
        model(16'd12000, 16'hF000, 16'h1234, mx, my, mz);
        out_ready = 1'b0; in_valid = 1'b1; x_in = 16'd12000; y_in = 16'hF000; z_in = 16'h1234;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin step(); n++; end
        chk("bp_lat", n, LAT, 0);
        for (int k = 0; k < 5; k++) begin
            in_valid = (k % 2 == 0);
            x_in = 16'($urandom); y_in = 16'($urandom); z_in = 16'($urandom);
            step();
            chk("bp_out_valid", int'(out_valid), 1, 0);
            chk("bp_in_ready", int'(in_ready), 0, 0);
            chk("bp_x_hold", int'($signed(x_out)), int'($signed(mx)), 0);
            chk("bp_y_hold", int'($signed(y_out)), int'($signed(my)), 0);
            chk("bp_z_hold", int'($signed(z_out)), int'($signed(mz)), 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("bp_release_out_valid", int'(out_valid), 0, 0);
        chk("bp_release_in_ready", int'(in_ready), 1, 0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (out_valid || !in_ready) n++;
        end
        chk("bp_no_stray_accept", n, 0, 0);
        chk("idle_x_kept", int'($signed(x_out)), int'($signed(mx)), 0);

        // Reset during the seventh micro-rotation
        in_valid = 1'b1; x_in = 16'd5000; y_in = 16'd3000; z_in = 16'h3000;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) step();
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0, 0);
        chk("mid_rst_in_ready", int'(in_ready), 1, 0);
        chk("mid_rst_x_out", int'(x_out), 0, 0);
        chk("mid_rst_y_out", int'(y_out), 0, 0);
        chk("mid_rst_z_out", int'(z_out), 0, 0);
        step();
        rst = 1'b0;
        step();
        run_op(16'hD8F0, 16'd7000, 16'hA000, lat, ax, ay, az);
        model(16'hD8F0, 16'd7000, 16'hA000, mx, my, mz);
        chk("post_rst_lat", lat, LAT, 0);
        chk("post_rst_x", int'($signed(ax)), int'($signed(mx)), 0);
        chk("post_rst_y", int'($signed(ay)), int'($signed(my)), 0);
        chk("post_rst_z", int'($signed(az)), int'($signed(mz)), 0);

        // Randomized traffic with random backpressure against the scoreboard
        begin
            int sent, got, cyc;
            logic acc, hs;
            logic [15:0] cx, cy, cz, ex, ey, ez;
            sent = 0; got = 0; cyc = 0;
            in_valid = 1'b0;
            while (got < NOPS && cyc < 5000) begin
                if (!in_valid && sent < NOPS && $urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    r = int'($urandom_range(0, 38000)) - 19000; x_in = 16'(r);
                    r = int'($urandom_range(0, 38000)) - 19000; y_in = 16'(r);
                    if ($urandom_range(0, 3) == 0) z_in = bnd_z[$urandom_range(0, 4)];
                    else z_in = 16'($urandom);
                end
                out_ready = ($urandom_range(0, 2) != 0);
                acc = in_valid && in_ready;
                hs  = out_valid && out_ready;
                cx = x_out; cy = y_out; cz = z_out;
                if (acc) begin
                    model(x_in, y_in, z_in, ex, ey, ez);
                    q_x.push_back(ex); q_y.push_back(ey); q_z.push_back(ez);
                end
                step();
                cyc++;
                if (acc) begin
                    sent++;
                    in_valid = 1'b0;
                end
                if (hs) begin
                    if (q_x.size() == 0) begin
                        chk("rand_unexpected_result", 1, 0, 0);
                    end else begin
                        ex = q_x.pop_front(); ey = q_y.pop_front(); ez = q_z.pop_front();
                        chk("rand_x", int'($signed(cx)), int'($signed(ex)), 0);
                        chk("rand_y", int'($signed(cy)), int'($signed(ey)), 0);
                        chk("rand_z", int'($signed(cz)), int'($signed(ez)), 0);
                    end
                    got++;
                end
            end
            chk("rand_ops_completed", got, NOPS, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
